// File: rtl/iir_pkg.sv
// Shared types, Q15.16 limits and the saturating 33-bit add/sub used by the biquad sequencer.
// Pure definitions: no latency, no flow control.
package iir_pkg;

    typedef logic signed [31:0] q16_t;

    localparam q16_t Q16_MAX = 32'sh7FFF_FFFF;
    localparam q16_t Q16_MIN = 32'sh8000_0000;
    localparam int   N_TERMS = 5;

    typedef enum logic [2:0] {
        COEF_B0 = 3'd0,
        COEF_B1 = 3'd1,
        COEF_B2 = 3'd2,
        COEF_A1 = 3'd3,
        COEF_A2 = 3'd4
    } coef_idx_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    typedef struct packed {
        logic sat;
        q16_t val;
    } sat_res_t;

    // Sum is formed one bit wider so overflow shows up as a sign/carry disagreement.
    function automatic sat_res_t sat_add32(input q16_t a, input q16_t b, input logic sub);
        logic [32:0] sum;
        sat_res_t    res;
        sum     = sub ? ({a[31], a} - {b[31], b}) : ({a[31], a} + {b[31], b});
        res.sat = 1'b0;
        res.val = sum[31:0];
        if (sum[32] != sum[31]) begin
            res.sat = 1'b1;
            res.val = sum[32] ? Q16_MIN : Q16_MAX;
        end
        return res;
    endfunction

endpackage

// File: rtl/iir_tag_pipe.sv
// DEPTH-stage delay line for {valid, subtract} tags riding alongside the multiplier.
// Latency DEPTH cycles (wire at 0); no backpressure, o_busy flags any tag still in flight.
module iir_tag_pipe #(
    parameter int DEPTH = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_vld,
    input  logic i_sub,
    output logic o_vld,
    output logic o_sub,
    output logic o_busy
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused_clk;
            assign w_unused_clk = clk ^ rst_n;
            assign o_vld  = i_vld;
            assign o_sub  = i_sub;
            assign o_busy = 1'b0;
        end else begin : g_pipe
            logic [DEPTH-1:0] r_vld;
            logic [DEPTH-1:0] r_sub;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= '0;
                    r_sub <= '0;
                end else begin
                    r_vld[0] <= i_vld;
                    r_sub[0] <= i_sub;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_vld[i] <= r_vld[i-1];
                        r_sub[i] <= r_sub[i-1];
                    end
                end
            end

            assign o_vld  = r_vld[DEPTH-1];
            assign o_sub  = r_sub[DEPTH-1];
            assign o_busy = |r_vld;
        end
    endgenerate

endmodule

// File: rtl/iir_biquad_sequencer.sv
// Direct-form-I biquad time-multiplexed over one external Q15.16 multiplier; result 6+MUL_LAT cycles after accept.
// One sample in flight: in_ready only in IDLE, result held in OUT until out_ready.
module iir_biquad_sequencer
    import iir_pkg::*;
#(
    parameter int MUL_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_sat,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    output logic        cfg_err,
    input  logic        hist_clr,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_p,
    input  logic        mul_ovf
);

    state_e   r_state;
    state_e   w_state_nxt;
    logic [2:0] r_k;

    q16_t     r_coef [N_TERMS];
    q16_t     r_x;
    q16_t     r_x1;
    q16_t     r_x2;
    q16_t     r_y1;
    q16_t     r_y2;
    q16_t     r_acc;
    q16_t     r_out_data;
    logic     r_sat;
    logic     r_out_sat;
    logic     r_cfg_err;

    q16_t     w_mul_a;
    q16_t     w_mul_b;
    logic     w_issue;
    logic     w_issue_sub;
    logic     w_in_ready;
    logic     w_out_valid;
    logic     w_tag_vld;
    logic     w_tag_sub;
    logic     w_tag_busy;
    logic     w_cfg_ok;
    logic     w_drain_done;
    sat_res_t w_acc_nxt;

    iir_tag_pipe #(
        .DEPTH (MUL_LAT)
    ) u_tag_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_vld  (w_issue),
        .i_sub  (w_issue_sub),
        .o_vld  (w_tag_vld),
        .o_sub  (w_tag_sub),
        .o_busy (w_tag_busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_issue = 1'b1;
                if (r_k == 3'(N_TERMS - 1)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!w_tag_busy) begin
                    w_state_nxt = ST_OUT;
                end
            end
            ST_OUT: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Feed-forward terms add, feedback terms (a1, a2) subtract.
    always_comb begin
        w_mul_a     = '0;
        w_mul_b     = '0;
        w_issue_sub = 1'b0;
        if (w_issue) begin
            case (coef_idx_e'(r_k))
                COEF_B0: begin
                    w_mul_a = r_coef[0];
                    w_mul_b = r_x;
                end
                COEF_B1: begin
                    w_mul_a = r_coef[1];
                    w_mul_b = r_x1;
                end
                COEF_B2: begin
                    w_mul_a = r_coef[2];
                    w_mul_b = r_x2;
                end
                COEF_A1: begin
                    w_mul_a     = r_coef[3];
                    w_mul_b     = r_y1;
                    w_issue_sub = 1'b1;
                end
                default: begin
                    w_mul_a     = r_coef[4];
                    w_mul_b     = r_y2;
                    w_issue_sub = 1'b1;
                end
            endcase
        end
    end

    assign w_cfg_ok     = cfg_we && (r_state == ST_IDLE) && (cfg_addr <= 3'd4);
    assign w_drain_done = (r_state == ST_DRAIN) && !w_tag_busy;
    assign w_acc_nxt    = sat_add32(r_acc, q16_t'(mul_p), w_tag_sub);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_TERMS; i++) begin
                r_coef[i] <= '0;
            end
            r_k        <= '0;
            r_x        <= '0;
            r_x1       <= '0;
            r_x2       <= '0;
            r_y1       <= '0;
            r_y2       <= '0;
            r_acc      <= '0;
            r_sat      <= 1'b0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !w_cfg_ok;

            if (w_cfg_ok) begin
                case (coef_idx_e'(cfg_addr))
                    COEF_B0: r_coef[0] <= cfg_data;
                    COEF_B1: r_coef[1] <= cfg_data;
                    COEF_B2: r_coef[2] <= cfg_data;
                    COEF_A1: r_coef[3] <= cfg_data;
                    default: r_coef[4] <= cfg_data;
                endcase
            end

            // A sample arriving in the same cycle wins over a history clear.
            if (r_state == ST_IDLE) begin
                if (in_valid) begin
                    r_x   <= in_data;
                    r_acc <= '0;
                    r_sat <= 1'b0;
                    r_k   <= '0;
                end else if (hist_clr) begin
                    r_x1 <= '0;
                    r_x2 <= '0;
                    r_y1 <= '0;
                    r_y2 <= '0;
                end
            end

            if (w_issue) begin
                r_k <= r_k + 3'd1;
            end

            if (w_tag_vld) begin
                r_acc <= w_acc_nxt.val;
                r_sat <= r_sat | w_acc_nxt.sat | mul_ovf;
            end

            if (w_drain_done) begin
                r_x2       <= r_x1;
                r_x1       <= r_x;
                r_y2       <= r_y1;
                r_y1       <= r_acc;
                r_out_data <= r_acc;
                r_out_sat  <= r_sat;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign cfg_err   = r_cfg_err;
    assign mul_a     = w_mul_a;
    assign mul_b     = w_mul_b;

endmodule
